// File: rtl/mem_wb_stage_unit_if.sv
// MEM/WB stage bundle: EX-side inputs, W-side outputs and the debug RAM port.
interface mem_wb_stage_unit_if #(
    parameter int RD_W    = 5,
    parameter int REGWR_W = 3
);
    logic               en;
    logic               clear;
    logic [31:0]        alu_out_e;
    logic [31:0]        store_data_e;
    logic [RD_W-1:0]    rd_e;
    logic [31:0]        pc_e;
    logic [3:0]         mem_write_e;
    logic [2:0]         load_type_e;
    logic [REGWR_W-1:0] reg_write_e;
    logic               mem_to_reg_e;
    logic               load_npc_e;

    logic [31:0]        alu_out_w;
    logic [RD_W-1:0]    rd_w;
    logic [31:0]        pc_w;
    logic [REGWR_W-1:0] reg_write_w;
    logic               mem_to_reg_w;
    logic               load_npc_w;
    logic [31:0]        load_data_w;
    logic               misalign_w;

    logic [31:0]        dbg_addr;
    logic [31:0]        dbg_wdata;
    logic [3:0]         dbg_we;
    logic [31:0]        dbg_rdata;

    modport master (
        output en, clear, alu_out_e, store_data_e, rd_e, pc_e, mem_write_e,
               load_type_e, reg_write_e, mem_to_reg_e, load_npc_e,
               dbg_addr, dbg_wdata, dbg_we,
        input  alu_out_w, rd_w, pc_w, reg_write_w, mem_to_reg_w, load_npc_w,
               load_data_w, misalign_w, dbg_rdata
    );

    modport slave (
        input  en, clear, alu_out_e, store_data_e, rd_e, pc_e, mem_write_e,
               load_type_e, reg_write_e, mem_to_reg_e, load_npc_e,
               dbg_addr, dbg_wdata, dbg_we,
        output alu_out_w, rd_w, pc_w, reg_write_w, mem_to_reg_w, load_npc_w,
               load_data_w, misalign_w, dbg_rdata
    );
endinterface

// File: rtl/mem_wb_stage_unit.sv
// MEM/WB segment register with dual-port byte-lane data RAM and load extension.
// Optional macro MISALIGN_TRAP_EN: flag and suppress misaligned halfword/word accesses.
module mem_wb_stage_unit #(
    parameter int DEPTH_LOG2 = 12,
    parameter int RD_W       = 5,
    parameter int REGWR_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    mem_wb_stage_unit_if.slave bus
);
    logic [31:0]           ram [0:(1 << DEPTH_LOG2) - 1];
    logic [DEPTH_LOG2-1:0] a_idx;
    logic [DEPTH_LOG2-1:0] b_idx;
    logic [1:0]            off_e;
    logic [3:0]            mask_e;
    logic [31:0]           wdata_e;
    logic                  mis_e;
    logic                  a_we;
    logic [31:0]           word_p1;
    logic [2:0]            load_type_p1;
    logic                  unused_dbg_bits;

    assign a_idx = bus.alu_out_e[DEPTH_LOG2+1:2];
    assign b_idx = bus.dbg_addr[DEPTH_LOG2+1:2];
    assign off_e = bus.alu_out_e[1:0];
    assign unused_dbg_bits = ^{bus.dbg_addr[31:DEPTH_LOG2+2], bus.dbg_addr[1:0]};

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  ltype);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (ltype)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    always_comb begin
        mask_e  = (bus.mem_write_e == 4'b1111) ? 4'b1111 : (bus.mem_write_e << off_e);
        wdata_e = (bus.mem_write_e == 4'b1111) ? bus.store_data_e
                                               : (bus.store_data_e << {off_e, 3'b000});
`ifdef MISALIGN_TRAP_EN
        mis_e = (((bus.mem_write_e == 4'b0011) ||
                  (bus.mem_to_reg_e && (bus.load_type_e == 3'b001 || bus.load_type_e == 3'b101)))
                 && off_e[0]) ||
                (((bus.mem_write_e == 4'b1111) ||
                  (bus.mem_to_reg_e && bus.load_type_e == 3'b010))
                 && (off_e != 2'b00));
`else
        mis_e = 1'b0;
`endif
        a_we = bus.en && !bus.clear && !mis_e;
    end

    // RAM: port B lanes first so port A overrides overlapping lanes of the same word
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.dbg_we[b])
                ram[b_idx][8*b +: 8] <= bus.dbg_wdata[8*b +: 8];
            if (a_we && mask_e[b])
                ram[a_idx][8*b +: 8] <= wdata_e[8*b +: 8];
        end
        if (bus.en)
            word_p1 <= ram[a_idx];
    end

    // W-stage control/pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_out_w    <= '0;
            bus.rd_w         <= '0;
            bus.pc_w         <= '0;
            bus.reg_write_w  <= '0;
            bus.mem_to_reg_w <= 1'b0;
            bus.load_npc_w   <= 1'b0;
            bus.misalign_w   <= 1'b0;
            load_type_p1     <= '0;
            bus.dbg_rdata    <= '0;
        end else begin
            bus.dbg_rdata <= ram[b_idx];
            if (bus.en) begin
                if (bus.clear) begin
                    bus.alu_out_w    <= '0;
                    bus.rd_w         <= '0;
                    bus.pc_w         <= '0;
                    bus.reg_write_w  <= '0;
                    bus.mem_to_reg_w <= 1'b0;
                    bus.load_npc_w   <= 1'b0;
                    bus.misalign_w   <= 1'b0;
                    load_type_p1     <= '0;
                end else begin
                    bus.alu_out_w    <= bus.alu_out_e;
                    bus.rd_w         <= bus.rd_e;
                    bus.pc_w         <= bus.pc_e;
                    bus.reg_write_w  <= bus.reg_write_e;
                    bus.mem_to_reg_w <= bus.mem_to_reg_e;
                    bus.load_npc_w   <= bus.load_npc_e;
                    bus.misalign_w   <= mis_e;
                    load_type_p1     <= bus.load_type_e;
                end
            end
        end
    end

    // Extension reads only held state, so it stays constant across any stall
    assign bus.load_data_w = (!bus.mem_to_reg_w || bus.misalign_w) ? 32'h0 :
                             extend_load(word_p1, bus.alu_out_w[1:0], load_type_p1);
endmodule
